// File: rtl/cam_pixel_capture.sv
// Camera capture front end: pairs RGB565 bytes into 8-bit pixels (RGB332 or
// luma), frames them with VSYNC/HREF and produces frame-buffer write strobes
// with a linear, row-aligned address.
module cam_pixel_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int OUT_GRAY = 0,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          cam_valid,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic          pix_we,
  output logic [7:0]    pix_data,
  output logic [AW-1:0] pix_addr,
  output logic          frame_start,
  output logic          frame_done,
  output logic          frame_ok,
  output logic          line_err
);

  // x saturates one past H_ACTIVE so over-long lines stay distinguishable.
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 1);
  // The address counter may rest at H*V after the last row, so it carries
  // one more value than the output address.
  localparam int CW = $clog2(H_ACTIVE * V_ACTIVE + 1);

  localparam logic [XW-1:0] X_END    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_SAT    = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_END    = YW'(V_ACTIVE);
  localparam logic [CW-1:0] ROW_STEP = CW'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE} state_t;

  state_t        state, state_n;
  logic          vsync_q, vsync_q_n;
  logic          href_q, href_q_n;
  logic          phase, phase_n;
  logic [7:0]    b0, b0_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [CW-1:0] wr_addr, wr_addr_n;
  logic [CW-1:0] row_base, row_base_n;
  logic          err_seen, err_seen_n;
  logic          pix_we_n;
  logic [7:0]    pix_data_n;
  logic [AW-1:0] pix_addr_n;
  logic          frame_start_n, frame_done_n, frame_ok_n, line_err_n;

  logic          vs_rise, vs_fall, line_end;

  function automatic logic [7:0] rgb332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

  // Components widened by bit replication; the weighted sum peaks at 2040,
  // so the 11-bit intermediate never overflows and no clamp is needed.
  function automatic logic [7:0] luma(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0]  r8, g8, b8;
    logic [10:0] sum;
    r8  = {hi[7:3], hi[7:5]};
    g8  = {hi[2:0], lo[7:5], hi[2:1]};
    b8  = {lo[4:0], lo[4:2]};
    sum = {2'b00, r8, 1'b0} + ({3'b000, g8} * 11'd5) + {3'b000, b8};
    return sum[10:3];
  endfunction

  function automatic logic [7:0] pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
    return (OUT_GRAY != 0) ? luma(hi, lo) : rgb332(hi, lo);
  endfunction

  assign vs_rise  = cam_vsync & ~vsync_q;
  assign vs_fall  = ~cam_vsync & vsync_q;
  // A line closes on HREF falling, or when VSYNC rises while HREF is still up.
  assign line_end = href_q & (~cam_href | vs_rise);

  // Next-state, byte pairing, counters and output pulses; all qualified by cam_valid.
  always_comb begin
    state_n       = state;
    vsync_q_n     = vsync_q;
    href_q_n      = href_q;
    phase_n       = phase;
    b0_n          = b0;
    x_n           = x;
    y_n           = y;
    wr_addr_n     = wr_addr;
    row_base_n    = row_base;
    err_seen_n    = err_seen;
    pix_we_n      = 1'b0;
    pix_data_n    = pix_data;
    pix_addr_n    = pix_addr;
    frame_start_n = 1'b0;
    frame_done_n  = 1'b0;
    frame_ok_n    = frame_ok;
    line_err_n    = 1'b0;

    if (cam_valid) begin
      vsync_q_n = cam_vsync;
      href_q_n  = cam_href;
      case (state)
        IDLE: begin
          // A capture may only begin from a clean vertical blank.
          if (cam_vsync) state_n = VBLANK;
        end
        VBLANK: begin
          if (vs_fall) begin
            frame_start_n = 1'b1;
            frame_ok_n    = 1'b0;
            err_seen_n    = 1'b0;
            x_n           = '0;
            y_n           = '0;
            phase_n       = 1'b0;
            wr_addr_n     = '0;
            row_base_n    = '0;
            state_n       = ACTIVE;
          end
        end
        ACTIVE: begin
          if (line_end) begin
            if (phase || (x != X_END)) begin
              line_err_n = 1'b1;
              err_seen_n = 1'b1;
            end
            x_n     = '0;
            phase_n = 1'b0;
            // Jump to the next row start so a short line cannot skew later rows.
            if (y < Y_END) begin
              y_n        = y + 1'b1;
              row_base_n = row_base + ROW_STEP;
              wr_addr_n  = row_base + ROW_STEP;
            end
          end else if (cam_href && !vs_rise) begin
            if (!phase) begin
              b0_n    = cam_data;
              phase_n = 1'b1;
            end else begin
              phase_n = 1'b0;
              if (x != X_SAT) x_n = x + 1'b1;
              if ((x < X_END) && (y < Y_END)) begin
                pix_we_n   = 1'b1;
                pix_data_n = pack_pixel(b0, cam_data);
                pix_addr_n = AW'(wr_addr);
                wr_addr_n  = wr_addr + 1'b1;
              end
            end
          end
          if (vs_rise) begin
            phase_n      = 1'b0;
            frame_done_n = 1'b1;
            frame_ok_n   = (y_n == Y_END) && !err_seen_n;
            state_n      = VBLANK;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers; async reset returns everything to IDLE/zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      b0          <= '0;
      x           <= '0;
      y           <= '0;
      wr_addr     <= '0;
      row_base    <= '0;
      err_seen    <= 1'b0;
      pix_we      <= 1'b0;
      pix_data    <= '0;
      pix_addr    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      state       <= state_n;
      vsync_q     <= vsync_q_n;
      href_q      <= href_q_n;
      phase       <= phase_n;
      b0          <= b0_n;
      x           <= x_n;
      y           <= y_n;
      wr_addr     <= wr_addr_n;
      row_base    <= row_base_n;
      err_seen    <= err_seen_n;
      pix_we      <= pix_we_n;
      pix_data    <= pix_data_n;
      pix_addr    <= pix_addr_n;
      frame_start <= frame_start_n;
      frame_done  <= frame_done_n;
      frame_ok    <= frame_ok_n;
      line_err    <= line_err_n;
    end
  end

endmodule
